fpu_alu_exec_element: RTL and testbench
=======================================

Name: fpu_alu_exec_element

Overview:
- Single-precision FPU ALU execution element for the core's exec stage.
- Performs one operation per run: abs, neg, add, sub, mul, div, int↔float convert, mov, sqrt. The operation is selected by the decoded instruction number.
- Each run is started by a reset pulse; completion is signalled by a sticky `completed` flag.

Parameters:
- DIV_SQRT_ITERS, 26, iterations of the shift-subtract divide/sqrt loop (24 result bits + guard + round).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears state and arms a new operation
- inst_num  in  6  decoded instruction number selecting the operation
- fs  in  32  first operand (IEEE-754 single, or int32 for CVT.S.W)
- ft  in  32  second operand
- out  out  32  result
- completed  out  1  high once `out` is valid; stays high until next reset

Behaviour:
- Reset (sync, active-high): `completed`=0, `out`=0, FSM→IDLE. Asserting reset mid-operation aborts the operation with no output change other than clearing.
- Run protocol:
  - Caller holds inst_num/fs/ft stable from reset assertion until `completed`.
  - The first rising edge with reset=0 latches the operands (edge E0) and FSM→EXEC.
- FSM states: IDLE→EXEC→DONE. DONE holds `out` and `completed`=1 until reset.
- Latency, counted after E0; `out` is valid in the same cycle `completed` rises:
  - 54,55,62, unknown: 1 edge
  - 56,57,58,60,61: 2 edges
  - 59,63: DIV_SQRT_ITERS+2 edges
- Opcodes:
  - 54 ABS.S: out = {0, fs[30:0]}
  - 55 NEG.S: out = {~fs[31], fs[30:0]}
  - 56 ADD.S: fs+ft
  - 57 SUB.S: fs−ft (add with ft sign inverted)
  - 58 MUL.S: fs*ft
  - 59 DIV.S: fs/ft
  - 60 CVT.S.W: signed int32 fs → float
  - 61 CVT.W.S: float fs → int32, round-nearest-even. Saturates to 0x7fffffff / 0x80000000 out of range; NaN→0x7fffffff.
  - 62 MOV.S: out = ft (fs ignored)
  - 63 SQRT.S: sqrt(fs); negative nonzero→0x7fc00000
  - Any other value: out=0, completed after 1 edge.
- Arithmetic rules:
  - Round-to-nearest-even on all rounding ops.
  - Denormal inputs and results flush to signed zero.
  - Exponent overflow → signed infinity.
  - Any NaN input → 0x7fc00000.
  - inf−inf, 0*inf, 0/0 and inf/inf → 0x7fc00000.
  - x/0 (x≠0) → signed infinity.
  - Exact-zero add/sub result → +0, except (−0)+(−0) → −0.
  - Result sign for mul/div = fs[31]^ft[31].
- Add/sub: align the smaller operand with a sticky bit, add/sub 27-bit mantissas, normalise with a leading-zero count, then round.
- Mul: 24×24 product, normalise by at most 1, then round.
- Div/sqrt: restoring iteration producing 1 bit per cycle, then round.

Decomposition:
- Shared package fpu_pkg:
  - opcode constants OP_ABS_S=54 … OP_SQRT_S=63
  - float field typedef (sign, exp[7:0], frac[22:0])
  - QNAN=32'h7fc00000
  - shared round-nearest-even function
- One sub-module, fpu_div_sqrt_iter: the iterative mantissa divider/square-root. It takes start plus op-select and outputs the quotient/root with a sticky bit and a done flag. All other operations are inline in the top.

Test Plan:
- ABS/NEG: 54 fs=ffffffff→7fffffff; 54 fs=7fffffff→7fffffff; 55 fs=7fffffff→ffffffff; 55 fs=ffffffff→7fffffff.
- ADD/SUB, all four sign combinations of 3.14 (4048f5c3) and 9.999 (411ffbe7):
  - 56 +,+ → 41523958; 56 +,− → c0db7cec; 56 −,+ → 40db7cec; 56 −,− → c1523958
  - 57 +,+ → c0db7cec; 57 +,− → 41523958; 57 −,+ → c1523958; 57 −,− → 40db7cec
- MUL/DIV, same operands: 58 → ±41fb2cc5 (sign = xor of input signs); 59 → ±3ea0c8ba (sign = xor of input signs).
- CVT/MOV:
  - 60 fs=1234567 → 4996b438; 60 fs=−98765432 → ccbc614f
  - 61 fs=4996b438 → 1234567
  - 62 fs=1, ft=f468fa99 → f468fa99
- SQRT/special cases: 63 fs=40800000 (4.0) → 40000000; 59 fs=3f800000, ft=0 → 7f800000; 56 fs=7f800000, ft=ff800000 → 7fc00000.
- Protocol:
  - `completed`=0 and `out`=0 while reset is held.
  - `completed` rises exactly at the stated latency and stays high for 10 idle cycles.
  - Reset asserted mid-DIV clears `completed` and restarts cleanly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision FPU ALU execution element.
// Contents: opcode numbers, IEEE-754 single field layout, quiet-NaN
// constant, FSM state type, round-to-nearest-even packer and a
// leading-zero counter shared by the add and int->float paths.
package fpu_pkg;

   localparam logic [5:0] OP_ABS_S   = 6'd54;
   localparam logic [5:0] OP_NEG_S   = 6'd55;
   localparam logic [5:0] OP_ADD_S   = 6'd56;
   localparam logic [5:0] OP_SUB_S   = 6'd57;
   localparam logic [5:0] OP_MUL_S   = 6'd58;
   localparam logic [5:0] OP_DIV_S   = 6'd59;
   localparam logic [5:0] OP_CVT_S_W = 6'd60;
   localparam logic [5:0] OP_CVT_W_S = 6'd61;
   localparam logic [5:0] OP_MOV_S   = 6'd62;
   localparam logic [5:0] OP_SQRT_S  = 6'd63;

   localparam logic [31:0] QNAN = 32'h7fc00000;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [22:0] frac;
   } float_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_t;

   // m[23] is the hidden one, e the biased exponent of that bit.
   // g is the first dropped bit, st the OR of everything below it.
   // Mantissa carry-out bumps the exponent; the exponent range check
   // happens after rounding so overflow gives infinity and underflow
   // flushes to signed zero.
   function automatic logic [31:0] round_pack(input logic s,
                                              input logic signed [10:0] e,
                                              input logic [23:0] m,
                                              input logic g,
                                              input logic st);
      logic [24:0]        mr;
      logic signed [10:0] er;
      mr = {1'b0, m} + {24'b0, (g & (st | m[0]))};
      er = e;
      if (mr[24]) begin
         mr = mr >> 1;
         er = e + 11'sd1;
      end
      if (er >= 11'sd255)
         return {s, 8'hff, 23'b0};
      else if (er <= 11'sd0)
         return {s, 31'b0};
      else
         return {s, er[7:0], mr[22:0]};
   endfunction

   function automatic logic [5:0] lzc32(input logic [31:0] v);
      logic [5:0] n;
      logic       found;
      n     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (!found) begin
            if (v[31-i]) found = 1'b1;
            else         n = n + 6'd1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fpu_div_sqrt_iter.sv
// Restoring mantissa divider / square-root, one result bit per clock.
// Ports:
//   clk, i_reset   - clock, synchronous active-high reset
//   i_start        - load operands (one-cycle pulse); iterations follow
//   i_sqrt         - 1: root of i_a, 0: i_a / i_b
//   i_a            - dividend {0,1.m} or radicand (1.m or 2*1.m, 23 frac bits)
//   i_b            - divisor 1.m
//   o_q            - 26-bit quotient (weight 2^0 at bit 25) or root
//   o_sticky       - nonzero final remainder
//   o_done         - high after ITERS iterations until next start/reset
// o_q is sized for 26 iterations (24 bits + guard + round).
module fpu_div_sqrt_iter #(
   parameter int unsigned ITERS = 26
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_sqrt,
   input  logic [24:0] i_a,
   input  logic [23:0] i_b,
   output logic [25:0] o_q,
   output logic        o_sticky,
   output logic        o_done
);

   localparam int unsigned CW = $clog2(ITERS + 1);

   logic [CW-1:0] r_cnt;
   logic          r_sqrt;
   logic          r_done;
   logic [23:0]   r_b;
   logic [29:0]   r_rem;
   logic [51:0]   r_rad;
   logic [25:0]   r_q;

   logic [29:0]   w_rem2;
   logic [29:0]   w_src;
   logic [29:0]   w_cmp;
   logic [29:0]   w_next;
   logic          w_ge;

   // Divide compares the remainder against the divisor; square root
   // brings down two radicand bits and compares against 4*root+1.
   always_comb begin
      w_rem2 = {r_rem[27:0], r_rad[51:50]};
      w_src  = r_sqrt ? w_rem2 : r_rem;
      w_cmp  = r_sqrt ? {2'b0, r_q, 2'b01} : {6'b0, r_b};
      w_ge   = (w_src >= w_cmp);
      w_next = w_ge ? (w_src - w_cmp) : w_src;
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_sqrt <= 1'b0;
         r_b    <= '0;
         r_rem  <= '0;
         r_rad  <= '0;
         r_q    <= '0;
      end else if (i_start) begin
         r_cnt  <= CW'(ITERS);
         r_done <= 1'b0;
         r_sqrt <= i_sqrt;
         r_b    <= i_b;
         r_rem  <= i_sqrt ? '0 : {5'b0, i_a};
         r_rad  <= {i_a, 27'b0};
         r_q    <= '0;
      end else if (r_cnt != '0) begin
         r_rem <= r_sqrt ? w_next : {w_next[28:0], 1'b0};
         r_rad <= {r_rad[49:0], 2'b00};
         r_q   <= {r_q[24:0], w_ge};
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CW'(1)) r_done <= 1'b1;
      end
   end

   assign o_q      = r_q;
   assign o_sticky = |r_rem;
   assign o_done   = r_done;

endmodule

// File: rtl/fpu_alu_exec_element.sv
// Single-precision FPU ALU execution element.
// Ports:
//   clk, reset  - clock; synchronous active-high reset arms a new run
//   inst_num    - decoded instruction number (54..63), held for the run
//   fs, ft      - operands (fs is int32 for CVT.S.W)
//   out         - result, valid when completed is high
//   completed   - sticky completion flag, cleared by reset
// Latency after the operand-latch edge: 1 edge (ABS/NEG/MOV/other),
// 2 edges (ADD/SUB/MUL/CVT), DIV_SQRT_ITERS+2 edges (DIV/SQRT).
module fpu_alu_exec_element
   import fpu_pkg::*;
#(
   parameter int unsigned DIV_SQRT_ITERS = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  inst_num,
   input  logic [31:0] fs,
   input  logic [31:0] ft,
   output logic [31:0] out,
   output logic        completed
);

   state_t      r_state;
   logic [31:0] r_fs, r_ft, r_res;
   logic [5:0]  r_op;
   logic        r_pend;

   float_t      w_a, w_b;
   logic [23:0] w_ma, w_mb;
   logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sx;
   logic        w_lat_two, w_lat_ds;
   logic [31:0] w_result;

   assign w_a      = r_fs;
   assign w_b      = r_ft;
   assign w_ma     = {1'b1, w_a.frac};
   assign w_mb     = {1'b1, w_b.frac};
   assign w_a_zero = (w_a.exp == 8'h00);
   assign w_b_zero = (w_b.exp == 8'h00);
   assign w_a_inf  = (w_a.exp == 8'hff) && (w_a.frac == '0);
   assign w_b_inf  = (w_b.exp == 8'hff) && (w_b.frac == '0);
   assign w_a_nan  = (w_a.exp == 8'hff) && (w_a.frac != '0);
   assign w_b_nan  = (w_b.exp == 8'hff) && (w_b.frac != '0);
   assign w_sx     = w_a.sign ^ w_b.sign;

   assign w_lat_two = (r_op inside {OP_ADD_S, OP_SUB_S, OP_MUL_S, OP_CVT_S_W, OP_CVT_W_S});
   assign w_lat_ds  = (r_op == OP_DIV_S) || (r_op == OP_SQRT_S);

   // Divide / square root iterator
   logic        w_ds_start, w_ds_sqrt, w_ds_sticky, w_ds_done;
   logic [24:0] w_ds_a;
   logic [25:0] w_ds_q;

   // Odd unbiased exponent (even biased) doubles the radicand so the
   // remaining exponent halves exactly.
   assign w_ds_sqrt  = (r_op == OP_SQRT_S);
   assign w_ds_a     = (w_ds_sqrt && !w_a.exp[0]) ? {w_ma, 1'b0} : {1'b0, w_ma};
   assign w_ds_start = (r_state == ST_EXEC) && w_lat_ds && !r_pend;

   fpu_div_sqrt_iter #(.ITERS(DIV_SQRT_ITERS)) u_div_sqrt (
      .clk      (clk),
      .i_reset  (reset),
      .i_start  (w_ds_start),
      .i_sqrt   (w_ds_sqrt),
      .i_a      (w_ds_a),
      .i_b      (w_mb),
      .o_q      (w_ds_q),
      .o_sticky (w_ds_sticky),
      .o_done   (w_ds_done)
   );

   // Add/sub datapath: larger magnitude first, smaller aligned with sticky
   logic               w_bs_eff, w_swap, w_big_s, w_sml_s;
   logic [7:0]         w_big_e, w_sml_e, w_diff;
   logic [23:0]        w_big_m, w_sml_m;
   logic [4:0]         w_dsh;
   logic [49:0]        w_sml_ext;
   logic [26:0]        w_big27, w_sml27, w_norm;
   logic [27:0]        w_sum;
   logic [5:0]         w_lz;
   logic [47:0]        w_prod;
   logic signed [10:0] w_mexp, w_dexp, w_sq_e, w_sq_exp;
   logic [31:0]        w_ci_mag, w_ci_norm;
   logic [5:0]         w_ci_lz, w_cw_sh;
   logic [63:0]        w_cw_v;
   logic [32:0]        w_cw_int;

   always_comb begin
      w_bs_eff  = w_b.sign ^ (r_op == OP_SUB_S);
      w_swap    = {w_b.exp, w_b.frac} > {w_a.exp, w_a.frac};
      w_big_s   = w_swap ? w_bs_eff : w_a.sign;
      w_sml_s   = w_swap ? w_a.sign : w_bs_eff;
      w_big_e   = w_swap ? w_b.exp  : w_a.exp;
      w_sml_e   = w_swap ? w_a.exp  : w_b.exp;
      w_big_m   = w_swap ? w_mb : w_ma;
      w_sml_m   = w_swap ? w_ma : w_mb;
      w_diff    = w_big_e - w_sml_e;
      // Beyond 26 places the whole smaller mantissa is sticky anyway
      w_dsh     = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];
      w_sml_ext = {w_sml_m, 26'b0} >> w_dsh;
      w_sml27   = {w_sml_ext[49:24], |w_sml_ext[23:0]};
      w_big27   = {w_big_m, 3'b000};
      w_sum     = (w_big_s == w_sml_s) ? ({1'b0, w_big27} + {1'b0, w_sml27})
                                       : ({1'b0, w_big27} - {1'b0, w_sml27});
      w_lz      = lzc32({w_sum[26:0], 5'b11111});
      w_norm    = w_sum[26:0] << w_lz;

      w_prod    = w_ma * w_mb;
      w_mexp    = $signed({3'b0, w_a.exp}) + $signed({3'b0, w_b.exp}) - 11'sd127;
      w_dexp    = $signed({3'b0, w_a.exp}) - $signed({3'b0, w_b.exp}) + 11'sd127;
      w_sq_e    = $signed({3'b0, w_a.exp}) - 11'sd127 - (w_a.exp[0] ? 11'sd0 : 11'sd1);
      w_sq_exp  = (w_sq_e >>> 1) + 11'sd127;

      w_ci_mag  = r_fs[31] ? (-r_fs) : r_fs;
      w_ci_lz   = lzc32(w_ci_mag);
      w_ci_norm = w_ci_mag << w_ci_lz;

      // Fixed point with 32 fraction bits: shift = unbiased exp + 9
      w_cw_sh   = 6'(w_a.exp - 8'd118);
      w_cw_v    = {40'b0, w_ma} << w_cw_sh;
      w_cw_int  = {1'b0, w_cw_v[63:32]}
                + {32'b0, w_cw_v[31] & ((|w_cw_v[30:0]) | w_cw_v[32])};
   end

   always_comb begin
      w_result = '0;
      case (r_op)
         OP_ABS_S:  w_result = {1'b0, r_fs[30:0]};
         OP_NEG_S:  w_result = {~r_fs[31], r_fs[30:0]};
         OP_MOV_S:  w_result = r_ft;
         OP_ADD_S, OP_SUB_S: begin
            if (w_a_nan || w_b_nan)     w_result = QNAN;
            else if (w_a_inf && w_b_inf) w_result = (w_a.sign != w_bs_eff) ? QNAN : {w_a.sign, 8'hff, 23'b0};
            else if (w_a_inf)           w_result = {w_a.sign, 8'hff, 23'b0};
            else if (w_b_inf)           w_result = {w_bs_eff, 8'hff, 23'b0};
            else if (w_a_zero && w_b_zero) w_result = {w_a.sign & w_bs_eff, 31'b0};
            else if (w_a_zero)          w_result = {w_bs_eff, r_ft[30:0]};
            else if (w_b_zero)          w_result = r_fs;
            else if (w_sum == '0)       w_result = '0;
            else if (w_sum[27])
               w_result = round_pack(w_big_s, $signed({3'b0, w_big_e}) + 11'sd1,
                                     w_sum[27:4], w_sum[3], |w_sum[2:0]);
            else
               w_result = round_pack(w_big_s, $signed({3'b0, w_big_e}) - $signed({5'b0, w_lz}),
                                     w_norm[26:3], w_norm[2], |w_norm[1:0]);
         end
         OP_MUL_S: begin
            if (w_a_nan || w_b_nan)                          w_result = QNAN;
            else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) w_result = QNAN;
            else if (w_a_inf || w_b_inf)                     w_result = {w_sx, 8'hff, 23'b0};
            else if (w_a_zero || w_b_zero)                   w_result = {w_sx, 31'b0};
            else if (w_prod[47])
               w_result = round_pack(w_sx, w_mexp + 11'sd1, w_prod[47:24], w_prod[23], |w_prod[22:0]);
            else
               w_result = round_pack(w_sx, w_mexp, w_prod[46:23], w_prod[22], |w_prod[21:0]);
         end
         OP_DIV_S: begin
            if (w_a_nan || w_b_nan)                          w_result = QNAN;
            else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) w_result = QNAN;
            else if (w_a_inf || w_b_zero)                    w_result = {w_sx, 8'hff, 23'b0};
            else if (w_b_inf || w_a_zero)                    w_result = {w_sx, 31'b0};
            else if (w_ds_q[25])
               w_result = round_pack(w_sx, w_dexp, w_ds_q[25:2], w_ds_q[1], w_ds_q[0] | w_ds_sticky);
            else
               w_result = round_pack(w_sx, w_dexp - 11'sd1, w_ds_q[24:1], w_ds_q[0], w_ds_sticky);
         end
         OP_SQRT_S: begin
            if (w_a_nan)       w_result = QNAN;
            else if (w_a_zero) w_result = {w_a.sign, 31'b0};
            else if (w_a.sign) w_result = QNAN;
            else if (w_a_inf)  w_result = {1'b0, 8'hff, 23'b0};
            else
               w_result = round_pack(1'b0, w_sq_exp, w_ds_q[25:2], w_ds_q[1], w_ds_q[0] | w_ds_sticky);
         end
         OP_CVT_S_W: begin
            if (w_ci_mag == '0) w_result = '0;
            else
               w_result = round_pack(r_fs[31], 11'sd158 - $signed({5'b0, w_ci_lz}),
                                     w_ci_norm[31:8], w_ci_norm[7], |w_ci_norm[6:0]);
         end
         OP_CVT_W_S: begin
            if (w_a_nan)                 w_result = 32'h7fffffff;
            else if (w_a.exp < 8'd126)   w_result = '0;
            else if (w_a.exp > 8'd157)   w_result = w_a.sign ? 32'h80000000 : 32'h7fffffff;
            else if (w_a.sign)           w_result = (w_cw_int > 33'h080000000) ? 32'h80000000 : -w_cw_int[31:0];
            else                         w_result = (w_cw_int > 33'h07fffffff) ? 32'h7fffffff : w_cw_int[31:0];
         end
         default:   w_result = '0;
      endcase
   end

   // Two-edge ops park the result in r_res for one cycle; DIV/SQRT use
   // r_pend to keep the iterator start a single pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_pend    <= 1'b0;
         out       <= '0;
         completed <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_fs    <= fs;
               r_ft    <= ft;
               r_op    <= inst_num;
               r_pend  <= 1'b0;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (w_lat_ds) begin
                  r_pend <= 1'b1;
                  if (r_pend && w_ds_done) begin
                     out       <= w_result;
                     completed <= 1'b1;
                     r_state   <= ST_DONE;
                  end
               end else if (w_lat_two && !r_pend) begin
                  r_res  <= w_result;
                  r_pend <= 1'b1;
               end else begin
                  out       <= w_lat_two ? r_res : w_result;
                  completed <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_alu_exec_element.sv
// Scoreboard bench for fpu_alu_exec_element: the driver pushes the
// hand-computed result and latency of each run; the monitor pops and
// compares whenever completed rises.
module tb_fpu_alu_exec_element;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  inst_num = '0;
   logic [31:0] fs = '0;
   logic [31:0] ft = '0;
   logic [31:0] out_w;
   logic        completed;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] val;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];

   localparam logic [31:0] A  = 32'h4048f5c3;  // 3.14
   localparam logic [31:0] B  = 32'h411ffbe7;  // 9.999
   localparam logic [31:0] NA = 32'hc048f5c3;
   localparam logic [31:0] NB = 32'hc11ffbe7;
   localparam int LAT1 = 1;
   localparam int LAT2 = 2;
   localparam int LATD = 28;

   fpu_alu_exec_element #(.DIV_SQRT_ITERS(26)) dut (
      .clk       (clk),
      .reset     (reset),
      .inst_num  (inst_num),
      .fs        (fs),
      .ft        (ft),
      .out       (out_w),
      .completed (completed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp_v);
      end
   endtask

   // Monitor: edge count since the operand-latch edge, compare on rise
   initial begin
      int   edges;
      logic prev;
      logic rst_s;
      exp_t e;
      edges = -1;
      prev  = 1'b0;
      forever begin
         @(posedge clk);
         rst_s = reset;
         #1;
         if (rst_s) edges = -1;
         else       edges++;
         if (completed && !prev) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_completion: out=%h with no pending run", out_w);
            end else begin
               e = sb.pop_front();
               check({e.name, " out"}, out_w, e.val);
               check({e.name, " latency"}, edges, e.lat);
            end
         end
         prev = completed;
      end
   end

   task automatic run_vec(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int lat);
      int   waited;
      logic ok;
      exp_t e;
      @(negedge clk);
      reset    = 1'b1;
      inst_num = op;
      fs       = a;
      ft       = b;
      e.val = expv; e.lat = lat; e.name = name;
      sb.push_back(e);
      @(negedge clk);
      check({name, " completed in reset"}, {31'b0, completed}, 32'd0);
      check({name, " out in reset"}, out_w, 32'd0);
      reset = 1'b0;
      waited = 0;
      while (!completed && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!completed) check({name, " timeout"}, {31'b0, completed}, 32'd1);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!completed || out_w !== expv) ok = 1'b0;
      end
      check({name, " hold"}, {31'b0, ok}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);

      run_vec("abs1", 6'd54, 32'hffffffff, 32'h0, 32'h7fffffff, LAT1);
      run_vec("abs2", 6'd54, 32'h7fffffff, 32'h0, 32'h7fffffff, LAT1);
      run_vec("neg1", 6'd55, 32'h7fffffff, 32'h0, 32'hffffffff, LAT1);
      run_vec("neg2", 6'd55, 32'hffffffff, 32'h0, 32'h7fffffff, LAT1);

      run_vec("add++", 6'd56, A,  B,  32'h41523958, LAT2);
      run_vec("add+-", 6'd56, A,  NB, 32'hc0db7cec, LAT2);
      run_vec("add-+", 6'd56, NA, B,  32'h40db7cec, LAT2);
      run_vec("add--", 6'd56, NA, NB, 32'hc1523958, LAT2);
      run_vec("sub++", 6'd57, A,  B,  32'hc0db7cec, LAT2);
      run_vec("sub+-", 6'd57, A,  NB, 32'h41523958, LAT2);
      run_vec("sub-+", 6'd57, NA, B,  32'hc1523958, LAT2);
      run_vec("sub--", 6'd57, NA, NB, 32'h40db7cec, LAT2);

      run_vec("mul++", 6'd58, A,  B,  32'h41fb2cc5, LAT2);
      run_vec("mul+-", 6'd58, A,  NB, 32'hc1fb2cc5, LAT2);
      run_vec("mul-+", 6'd58, NA, B,  32'hc1fb2cc5, LAT2);
      run_vec("mul--", 6'd58, NA, NB, 32'h41fb2cc5, LAT2);
      run_vec("div++", 6'd59, A,  B,  32'h3ea0c8ba, LATD);
      run_vec("div+-", 6'd59, A,  NB, 32'hbea0c8ba, LATD);
      run_vec("div-+", 6'd59, NA, B,  32'hbea0c8ba, LATD);
      run_vec("div--", 6'd59, NA, NB, 32'h3ea0c8ba, LATD);

      run_vec("cvtsw_pos", 6'd60, 32'd1234567, 32'h0, 32'h4996b438, LAT2);
      run_vec("cvtsw_neg", 6'd60, -32'sd98765432, 32'h0, 32'hccbc614f, LAT2);
      run_vec("cvtws", 6'd61, 32'h4996b438, 32'h0, 32'd1234567, LAT2);
      run_vec("mov", 6'd62, 32'h1, 32'hf468fa99, 32'hf468fa99, LAT1);

      run_vec("sqrt4", 6'd63, 32'h40800000, 32'h0, 32'h40000000, LATD);
      run_vec("div_by_zero", 6'd59, 32'h3f800000, 32'h0, 32'h7f800000, LATD);
      run_vec("inf_minus_inf", 6'd56, 32'h7f800000, 32'hff800000, 32'h7fc00000, LAT2);
      run_vec("unknown_op", 6'd0, A, B, 32'h0, LAT1);

      // Abort a divide part-way through, then rerun it cleanly
      @(negedge clk);
      reset    = 1'b1;
      inst_num = 6'd59;
      fs       = A;
      ft       = B;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("abort div still busy", {31'b0, completed}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("abort completed cleared", {31'b0, completed}, 32'd0);
      check("abort out cleared", out_w, 32'd0);
      run_vec("div_after_abort", 6'd59, A, B, 32'h3ea0c8ba, LATD);

      repeat (5) @(negedge clk);
      check("scoreboard drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
